seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clk, with a qualifying valid strobe.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repetitions.
- Stimulus source for the team's serial sequence detectors; d_out/d_valid connect directly to a detector's serial input. Default pattern width 4 matches the 1010 detector.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 8, width of the repeat count.
- GAP_W, 4, width of the inter-repetition gap length.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel of a transfer in progress.
- pattern  input  PAT_W  pattern to send; latched on accepted start.
- repeat_cnt  input  CNT_W  number of repetitions; latched on accepted start.
- gap_len  input  GAP_W  idle cycles between repetitions; latched on accepted start.
- d_out  output  1  serial data bit; 0 whenever d_valid=0.
- d_valid  output  1  high while d_out carries a pattern bit.
- busy  output  1  high from start acceptance until done or abort.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- All outputs registered. Reset is synchronous, active-high on rst, clock clk; while rst is high at a posedge, the next state is IDLE and d_out=0, d_valid=0, busy=0, done=0. Internal registers clear to 0. No initial blocks; reset is the only initialisation.
- FSM states: IDLE, SHIFT, GAP, FIN.
- IDLE: if start=1 and repeat_cnt!=0, latch pattern/repeat_cnt/gap_len and go to SHIFT. d_out=pattern[PAT_W-1], d_valid=1, busy=1 in the next cycle, so latency is 1 cycle from the start cycle to the first bit.
- IDLE: if start=1 and repeat_cnt==0, go to FIN. No bits are sent; done pulses in the next cycle.
- SHIFT: each cycle presents the next bit MSB-first. A bit counter runs 0..PAT_W-1. On the last bit, decrement the remaining-repeat count.
  - Remaining repeats 0: go to FIN.
  - Remaining repeats >0 and gap_len==0: reload the pattern and stay in SHIFT. Repetitions are back-to-back with no bubble.
  - Remaining repeats >0 and gap_len>0: go to GAP.
- GAP: d_valid=0, d_out=0, busy=1 for exactly gap_len cycles, then reload and go to SHIFT.
- FIN: done=1, busy=0, d_valid=0 for one cycle, then IDLE. start in the FIN cycle is ignored.
- Total cycles with d_valid=1 per transfer: repeat_cnt*PAT_W. Span from first to last bit: repeat_cnt*PAT_W + (repeat_cnt-1)*gap_len cycles.
- start while busy: ignored. Latched pattern/count/gap are unaffected by later input changes.
- abort=1 in SHIFT or GAP: next cycle IDLE, all outputs 0, and done is NOT pulsed. abort in IDLE has no effect and takes priority over start in the same cycle.
- rst has priority over abort and start; reset mid-transfer truncates the stream silently.
- Counter widths: repeat counter CNT_W bits, gap counter GAP_W bits, bit index clog2(PAT_W) bits. No wrap: counters stop at their terminal value.

Decomposition:
- Shared package seq_pkg holds the state encoding constants (IDLE=0, SHIFT=1, GAP=2, FIN=3) and a default pattern constant 4'b1010 used by the detector benches.
- One natural sub-module: seq_piso, a PAT_W-bit parallel-load, MSB-first shift register with load/shift enables. The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> d_out=0, d_valid=0, busy=0, done=0 on the first posedge; start one cycle after release accepted normally.
- pattern=1010, repeat_cnt=2, gap_len=0 -> d_out 1,0,1,0,1,0,1,0 with d_valid high for 8 consecutive cycles starting the cycle after start; done pulses on cycle 9. Also feed into the Moore 1010 detector and check its out pulses.
- pattern=1100, repeat_cnt=3, gap_len=2 -> bits 1100, 2 idle, 1100, 2 idle, 1100; 12 valid cycles over a 16-cycle span; done once.
- repeat_cnt=0 with start -> no d_valid cycles; busy stays 0; done pulses one cycle after start.
- start re-asserted mid-transfer with a different pattern -> ignored; original stream completes unchanged.
- abort during the 2nd bit of pattern 1010 -> next cycle d_valid=0, busy=0, and no done pulse; new start accepted the following cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default pattern for the serial sequence blocks
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;
  localparam logic [3:0] DEF_PAT = 4'b1010;
endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-load, MSB-first shift register
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         so
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[W-2:0], 1'b0};
  assign so = q[W-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: repeats a latched pattern MSB-first on d_out with programmable idle gaps
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);
  state_t state, state_n;
  logic [PAT_W-1:0] pat_r, src, ld_d;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap_r, gcnt;
  logic [IW-1:0] idx;
  logic acc, last, gap_end, load, dv_n, busy_n, done_n;
  assign acc = state == IDLE && start && !abort;
  assign last = state == SHIFT && idx == LAST;
  assign gap_end = state == GAP && gcnt == gap_r - GAP_W'(1);
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      d_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pat_r   <= '0;
      rem     <= '0;
      gap_r   <= '0;
      gcnt    <= '0;
      idx     <= '0;
    end else begin
      state   <= state_n;
      d_valid <= dv_n;
      busy    <= busy_n;
      done    <= done_n;
      if (acc) begin
        pat_r <= pattern;
        rem   <= repeat_cnt;
        gap_r <= gap_len;
      end else if (last && rem != '0) rem <= rem - CNT_W'(1);
      idx  <= load ? '0 : (state == SHIFT && idx != LAST) ? idx + IW'(1) : idx;
      gcnt <= state != GAP ? '0 : gap_end ? gcnt : gcnt + GAP_W'(1);
    end
  always_comb begin
    state_n = state == IDLE ? (acc ? (repeat_cnt != '0 ? SHIFT : FIN) : IDLE)
            : state == FIN  ? IDLE
            : abort         ? IDLE
            : state == SHIFT ? (last ? (rem == CNT_W'(1) ? FIN : gap_r == '0 ? SHIFT : GAP) : SHIFT)
            : gap_end ? SHIFT : GAP;
  end
  // the shifter is loaded with zeros outside SHIFT so its MSB is a clean registered d_out
  always_comb begin
    load   = !(state == SHIFT && state_n == SHIFT && !last);
    src    = state == IDLE ? pattern : pat_r;
    ld_d   = state_n == SHIFT ? src : '0;
    dv_n   = state_n == SHIFT;
    busy_n = state_n == SHIFT || state_n == GAP;
    done_n = state_n == FIN;
  end
  seq_piso #(.W(PAT_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(!load),
    .d    (ld_d),
    .so   (d_out)
  );
endmodule
